// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider used by the EX stage for DIV/DIVU.
// One quotient bit is produced per clock. The EX stage is stalled until the
// {remainder, quotient} result is ready for the HI/LO write path.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   start_i     divide request, held high until ready_o is seen
//   signed_i    1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//   opdata1_i   dividend, sampled with start
//   opdata2_i   divisor, sampled with start
//   annul_i     pipeline flush; aborts any operation in flight
//   result_o    {remainder, quotient}; non-zero only while ready_o = 1
//   ready_o     result valid
//   stallreq_o  stall request to the stall controller (combinational)
module div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0]   ZERO     = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0]   ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [2*DATA_W-1:0] ZERO_RES = {(2*DATA_W){1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   rem;       // partial remainder
    logic [DATA_W-1:0]   quo;       // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]   dvs;       // divisor magnitude
    logic                neg_quo;
    logic                neg_rem;

    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   step_rem;
    logic [DATA_W-1:0]   step_quo;
    logic [DATA_W-1:0]   fin_rem;
    logic [DATA_W-1:0]   fin_quo;

    // Two's-complement negation modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] neg2(input logic [DATA_W-1:0] v);
        return (~v) + ONE;
    endfunction

    // Magnitude of an operand: absolute value only for negative signed inputs.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                              input logic is_signed);
        if (is_signed && v[DATA_W-1]) begin
            return neg2(v);
        end else begin
            return v;
        end
    endfunction

    // One restoring step: shift the next dividend bit into the remainder and
    // trial-subtract; the borrow bit of the wider subtraction says "negative".
    always_comb begin
        trial    = {rem, quo[DATA_W-1]} - {1'b0, dvs};
        step_quo = {quo[DATA_W-2:0], ~trial[DATA_W]};
        if (trial[DATA_W]) begin
            step_rem = {rem[DATA_W-2:0], quo[DATA_W-1]};
        end else begin
            step_rem = trial[DATA_W-1:0];
        end
    end

    // Sign correction applied to the final step's outputs.
    always_comb begin
        if (neg_quo) begin
            fin_quo = neg2(step_quo);
        end else begin
            fin_quo = step_quo;
        end
        if (neg_rem) begin
            fin_rem = neg2(step_rem);
        end else begin
            fin_rem = step_rem;
        end
    end

    // Stall while a divide is being requested or running; a flush or reset releases it.
    always_comb begin
        if (rst || annul_i) begin
            stallreq_o = 1'b0;
        end else begin
            stallreq_o = ((state == IDLE) && start_i) || (state == ON) || (state == DIVZERO);
        end
    end

    // Sequencer FSM with registered result/ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= CNT_ZERO;
            rem      <= ZERO;
            quo      <= ZERO;
            dvs      <= ZERO;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= ZERO_RES;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == ZERO) begin
                            state <= DIVZERO;
                        end else begin
                            state   <= ON;
                            cnt     <= CNT_ZERO;
                            rem     <= ZERO;
                            quo     <= mag(opdata1_i, signed_i);
                            dvs     <= mag(opdata2_i, signed_i);
                            neg_quo <= signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            neg_rem <= signed_i & opdata1_i[DATA_W-1];
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                DIVZERO: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        state    <= DONE;
                        ready_o  <= 1'b1;
                        result_o <= ZERO_RES;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        rem <= step_rem;
                        quo <= step_quo;
                        cnt <= cnt + CNT_ONE;
                        if (cnt == CNT_LAST) begin
                            state    <= DONE;
                            ready_o  <= 1'b1;
                            result_o <= {fin_rem, fin_quo};
                        end else begin
                            state <= ON;
                        end
                    end
                end
                DONE: begin
                    if (!start_i || annul_i) begin
                        state    <= IDLE;
                        ready_o  <= 1'b0;
                        result_o <= ZERO_RES;
                    end else begin
                        state <= DONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ready_o  <= 1'b0;
                    result_o <= ZERO_RES;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq with hand-computed expected results.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int errors = 0;
    int checks = 0;

    div_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue a divide from IDLE, count stall cycles, check the result, hold start
    // for 'hold' extra cycles, then drop start and check the outputs clear.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int exp_stall,
                          input int hold);
        int n;
        n = 0;
        start_i   = 1'b1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        #1;
        while (stallreq_o && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk({tag, "_stall"}, 64'(n), 64'(exp_stall));
        chk({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
        chk({tag, "_res"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_res"}, result_o, exp);
            chk({tag, "_hold_stall"}, {63'd0, stallreq_o}, 64'd0);
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_clr_ready"}, {63'd0, ready_o}, 64'd0);
        chk({tag, "_clr_res"}, result_o, 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        annul_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_res", result_o, 64'd0);
        chk("rst_stall", {63'd0, stallreq_o}, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;

        // Unsigned 100/7 with start held past ready.
        do_div("u100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 5);
        do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33, 0);
        do_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 33, 0);
        do_div("s_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFF, 32'h3}, 33, 0);
        do_div("u_big_2", 32'hFFFF_FFF9, 32'd2, 1'b0, {32'h1, 32'h7FFF_FFFC}, 33, 0);
        do_div("divzero", 32'd5, 32'd0, 1'b0, 64'd0, 2, 1);

        // Annul mid-operation at step 10, then a fresh 9/3.
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        chk("annul_stall_comb", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("annul_idle", {63'd0, stallreq_o}, 64'd0);
        chk("annul_ready", {63'd0, ready_o}, 64'd0);
        chk("annul_res", result_o, 64'd0);
        do_div("u9_3", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 33, 0);

        // Annul while in the divide-by-zero state.
        start_i   = 1'b1;
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("dz_annul_idle", {63'd0, stallreq_o}, 64'd0);
        chk("dz_annul_ready", {63'd0, ready_o}, 64'd0);

        // Reset at step 20 with start held; the held start restarts afterwards.
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_ready", {63'd0, ready_o}, 64'd0);
        chk("mrst_res", result_o, 64'd0);
        chk("mrst_stall", {63'd0, stallreq_o}, 64'd0);
        rst = 1'b0;
        do_div("restart", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
